io_responder32: RTL
===================

# io_responder32

Memory-mapped I/O responder for the single-cycle CPU. It answers the `IORead`/`IOWrite` strobes that the control unit raises for loads and stores to the top 1 KiB of the address space (0xFFFFFC00–0xFFFFFFFF). It owns the LED register, synchronised switch and button inputs with sticky press flags, and an optional compare timer. It sits beside data memory; its `io_rdata` is muxed with memory read data onto the register write-back path.

## Interface
Parameters:
- `LED_W`, 24: LED register width.
- `SW_W`, 24: switch input width.
- `BTN_W`, 5: button input width.
- `PRESCALE`, 100: clock cycles per timer tick. Legal range is ≥1.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `IORead` in 1: I/O load strobe from control.
- `IOWrite` in 1: I/O store strobe from control.
- `io_addr` in 10: `Alu_result[9:0]`, the byte offset within the I/O page.
- `io_wdata` in 32: store data, register rt.
- `io_rdata` out 32: load data.
- `switch_in` in SW_W: asynchronous board switches.
- `button_in` in BTN_W: asynchronous board buttons, active-high.
- `led_out` out LED_W: LED drive.
- `timer_irq` out 1: level copy of the timer match flag.

## Operation
Address map. Offsets are word-aligned; any offset with `io_addr[1:0]` ≠ 0 is unmapped.
- 0x060 LED (R/W): `led_out` = the register. Reads return it zero-extended.
- 0x070 SW (R): synchronised switches, zero-extended.
- 0x074 BTN (R, read-clear): bit i is set on a rising edge of synchronised `button_in[i]`.
- 0x078 TCOUNT (R/W): timer count. A write loads `io_wdata`.
- 0x07C TCMP (R/W): compare value. 0 disables the timer.
- 0x080 TSTAT (R, read-clear): bit0 is the match flag.

Rules:
- Unmapped reads return 0. Unmapped writes are ignored.
- `io_rdata` is combinational from current register state when `IORead`=1, and is 0 otherwise.
- Read-clear: at the clock edge where `IORead`=1 and the address hits BTN or TSTAT, the flag bits clear. The value returned in that cycle is the pre-clear value.
- Simultaneous event and read-clear: a new set event in the same cycle wins, so the bit stays 1.
- Timer:
  - The prescaler counts 0..PRESCALE-1 while TCMP ≠ 0. On wrap it produces a tick.
  - On a tick, if TCOUNT == TCMP: TCOUNT becomes 0 and the match flag is set. Otherwise TCOUNT increments, wrapping modulo 2^32.
  - A write to TCOUNT takes priority over a tick in the same cycle and also clears the prescaler.
  - A write to TCMP does not reset TCOUNT.
  - If TCMP is written below the current TCOUNT, the timer runs through the 32-bit wrap before matching.
- `IORead` and `IOWrite` both high at the same address: the write is performed, and the read returns the pre-write value. This never occurs from the CPU but is defined.
- Reset values: `led_out` = 0, `io_rdata` = 0, `timer_irq` = 0. The synchroniser flops, button previous-state flops, BTN flags, TCOUNT, TCMP, prescaler and match flag all reset to 0.
- Reset asserted mid-operation overrides any same-cycle write or event. All state reads as 0 on the first cycle after reset deasserts.

## Timing
- Writes commit on the rising edge where `IOWrite`=1. `led_out` changes in the following cycle.
- Read latency is zero (combinational), which fits the single-cycle datapath.
- Switch change reaches SW after 2 edges.
- Button rising edge: the flag sets on the 3rd edge after the pin rises (2 sync edges plus the edge-detect edge).
- With TCMP = N, the match flag sets (N+1)·PRESCALE cycles after the timer starts from TCOUNT = 0.
- `timer_irq` rises in the same cycle as the match flag.

## Configuration
- `IO_TIMER_EN` defined: the prescaler, TCOUNT, TCMP, TSTAT and `timer_irq` logic are present.
- `IO_TIMER_EN` undefined:
  - Offsets 0x078–0x080 behave as unmapped: reads return 0, writes are ignored.
  - `timer_irq` is tied to 0.
  - No timer flops are synthesised.

## Structure
- Package `io_map_pkg` holds:
  - Offset constants: `IO_LED_OFS`, `IO_SW_OFS`, `IO_BTN_OFS`, `IO_TCNT_OFS`, `IO_TCMP_OFS`, `IO_TSTAT_OFS`.
  - The I/O page width (10).
  - Default widths.
- Sub-module `io_sync2`: a parameterised-width 2-flop synchroniser with synchronous reset. It is instantiated once for the switches and once for the buttons.

## Test plan
- Reset, then write 0x00A5A5A5 to 0x060 → `led_out` = 0xA5A5A5 next cycle; a read of 0x060 returns 0x00A5A5A5.
- Set `switch_in` = 0x123456 → read of 0x070 returns 0x00123456 from the 3rd cycle on, and 0 before that.
- Pulse `button_in[2]` → BTN read returns 0x4. The same-cycle read clears it, so the next read returns 0. A new rising edge coinciding with the read leaves the bit at 1.
- Timer test with PRESCALE=2, TCMP=3:
  - Match flag and `timer_irq` = 1 at cycle 8 after the TCMP write.
  - TSTAT read returns 1 and clears `timer_irq`.
  - Writing TCOUNT=0xFFFFFFFF with TCMP=3 → the next match occurs after the wrap.
- Reads of 0x064 and 0x061, and a write to 0x3FC → read data 0 and no state change. With `IO_TIMER_EN` undefined, a read of 0x078 returns 0.
- Assert `reset` while a write to 0x060 is in the same cycle → `led_out` = 0; BTN and TSTAT read 0 after release.

Source files
------------

// File: rtl/io_map_pkg.sv
// io_map_pkg: shared address map, widths and register decode for the
// memory-mapped I/O responder of the single-cycle CPU.
package io_map_pkg;

  localparam int IO_PAGE_W    = 10;
  localparam int IO_DATA_W    = 32;
  localparam int IO_LED_W_DEF = 24;
  localparam int IO_SW_W_DEF  = 24;
  localparam int IO_BTN_W_DEF = 5;

  localparam logic [IO_PAGE_W-1:0] IO_LED_OFS   = 10'h060;
  localparam logic [IO_PAGE_W-1:0] IO_SW_OFS    = 10'h070;
  localparam logic [IO_PAGE_W-1:0] IO_BTN_OFS   = 10'h074;
  localparam logic [IO_PAGE_W-1:0] IO_TCNT_OFS  = 10'h078;
  localparam logic [IO_PAGE_W-1:0] IO_TCMP_OFS  = 10'h07C;
  localparam logic [IO_PAGE_W-1:0] IO_TSTAT_OFS = 10'h080;

  typedef enum logic [2:0] {
    IO_REG_NONE,
    IO_REG_LED,
    IO_REG_SW,
    IO_REG_BTN,
    IO_REG_TCNT,
    IO_REG_TCMP,
    IO_REG_TSTAT
  } io_reg_e;

  // Exact match on the full offset, so misaligned offsets fall to NONE.
  function automatic io_reg_e io_decode(input logic [IO_PAGE_W-1:0] addr);
    io_reg_e sel;
    case (addr)
      IO_LED_OFS:   sel = IO_REG_LED;
      IO_SW_OFS:    sel = IO_REG_SW;
      IO_BTN_OFS:   sel = IO_REG_BTN;
      IO_TCNT_OFS:  sel = IO_REG_TCNT;
      IO_TCMP_OFS:  sel = IO_REG_TCMP;
      IO_TSTAT_OFS: sel = IO_REG_TSTAT;
      default:      sel = IO_REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/io_sync2.sv
// io_sync2: parameterised-width two-flop synchroniser with synchronous reset.
module io_sync2 #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync_p0;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= '0;
      q       <= '0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/io_responder32.sv
// io_responder32: memory-mapped I/O responder (LED, switches, buttons with
// sticky press flags, optional compare timer). The timer block is built only
// when the macro IO_TIMER_EN is defined; otherwise its offsets are unmapped.
module io_responder32
  import io_map_pkg::*;
#(
  parameter int LED_W    = IO_LED_W_DEF,
  parameter int SW_W     = IO_SW_W_DEF,
  parameter int BTN_W    = IO_BTN_W_DEF,
  parameter int PRESCALE = 100
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 IORead,
  input  logic                 IOWrite,
  input  logic [IO_PAGE_W-1:0] io_addr,
  input  logic [31:0]          io_wdata,
  output logic [31:0]          io_rdata,
  input  logic [SW_W-1:0]      switch_in,
  input  logic [BTN_W-1:0]     button_in,
  output logic [LED_W-1:0]     led_out,
  output logic                 timer_irq
);

  io_reg_e          sel;
  logic             wr_led;
  logic             rd_btn;
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_sync;
  logic [BTN_W-1:0] btn_sync;
  logic [BTN_W-1:0] btn_prev;
  logic [BTN_W-1:0] btn_rise;
  logic [BTN_W-1:0] btn_flags;

  assign sel      = io_decode(io_addr);
  assign wr_led   = IOWrite && (sel == IO_REG_LED);
  assign rd_btn   = IORead && (sel == IO_REG_BTN);
  assign btn_rise = btn_sync & ~btn_prev;
  assign led_out  = led_q;

  io_sync2 #(.W(SW_W)) u_sw_sync (
    .clock (clock),
    .reset (reset),
    .d     (switch_in),
    .q     (sw_sync)
  );

  io_sync2 #(.W(BTN_W)) u_btn_sync (
    .clock (clock),
    .reset (reset),
    .d     (button_in),
    .q     (btn_sync)
  );

  // LED register, button edge detect and sticky flags (a new edge beats read-clear)
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q     <= '0;
      btn_prev  <= '0;
      btn_flags <= '0;
    end else begin
      if (wr_led) led_q <= io_wdata[LED_W-1:0];
      btn_prev  <= btn_sync;
      btn_flags <= (rd_btn ? '0 : btn_flags) | btn_rise;
    end
  end

`ifdef IO_TIMER_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] presc;
  logic [31:0]     tcount;
  logic [31:0]     tcmp;
  logic            match_flag;
  logic            wr_tcnt;
  logic            wr_tcmp;
  logic            rd_tstat;
  logic            tick;
  logic            tick_eff;
  logic            hit;

  assign wr_tcnt   = IOWrite && (sel == IO_REG_TCNT);
  assign wr_tcmp   = IOWrite && (sel == IO_REG_TCMP);
  assign rd_tstat  = IORead && (sel == IO_REG_TSTAT);
  assign tick      = (tcmp != 32'd0) && (presc == PS_W'(PRESCALE - 1));
  // A software load of TCOUNT swallows a coincident tick entirely.
  assign tick_eff  = tick && !wr_tcnt;
  assign hit       = tick_eff && (tcount == tcmp);
  assign timer_irq = match_flag;

  // Prescaler, compare counter and sticky match flag
  always_ff @(posedge clock) begin
    if (reset) begin
      presc      <= '0;
      tcount     <= '0;
      tcmp       <= '0;
      match_flag <= 1'b0;
    end else begin
      if (wr_tcnt) begin
        tcount <= io_wdata;
        presc  <= '0;
      end else begin
        if (tcmp != 32'd0) presc <= tick ? '0 : presc + 1'b1;
        if (tick_eff)      tcount <= hit ? 32'd0 : tcount + 32'd1;
      end
      if (wr_tcmp) tcmp <= io_wdata;
      match_flag <= (rd_tstat ? 1'b0 : match_flag) | hit;
    end
  end
`else
  logic unused_wdata;

  assign unused_wdata = ^io_wdata;
  assign timer_irq    = 1'b0;
`endif

  // Combinational read mux; the value seen is always the pre-edge state
  always_comb begin
    io_rdata = '0;
    if (IORead) begin
      case (sel)
        IO_REG_LED:   io_rdata = 32'(led_q);
        IO_REG_SW:    io_rdata = 32'(sw_sync);
        IO_REG_BTN:   io_rdata = 32'(btn_flags);
`ifdef IO_TIMER_EN
        IO_REG_TCNT:  io_rdata = tcount;
        IO_REG_TCMP:  io_rdata = tcmp;
        IO_REG_TSTAT: io_rdata = {31'd0, match_flag};
`endif
        default:      io_rdata = '0;
      endcase
    end
  end

endmodule
